// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer: drives a word-addressed data memory over a
// req/gnt/rvalid handshake, stalls the pipeline while busy and formats lb/sb.
module mem_access_sequencer #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              is_lb,
   input  logic              is_sb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [4:0]        rd,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic               we_q, byte_q;
   logic [1:0]         off_q;
   logic [ADDR_W-1:2]  addr_q;
   logic [3:0]         be_q;
   logic [31:0]        wdata_q;
   logic [4:0]         rd_q;
   logic [7:0]         cnt_q, cnt_d;
   logic               err_q;
   logic [4:0]         wb_rd_q;
   logic [31:0]        wb_data_q;

   logic               one_op, misaligned, accept, reject;
   logic               capture, load_data, abort, expired;
   logic [31:0]        lb_word;
   logic [31:0]        load_result;

   assign one_op     = memread ^ memwrite;
   assign misaligned = one_op & ((memread & ~is_lb) | (memwrite & ~is_sb)) & (addr[1:0] != 2'b00);
   assign accept     = start & one_op & ~misaligned;
   assign reject     = start & ((memread & memwrite) | misaligned);
   // The last permitted cycle in REQ/WAIT is the one where the counter sits at TIMEOUT-1.
   assign expired    = (cnt_q >= TimeoutLast);

   assign lb_word     = mem_rdata >> {off_q, 3'b000};
   assign load_result = byte_q ? {{24{lb_word[7]}}, lb_word[7:0]} : mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      load_data = 1'b0;
      abort     = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StReq;
               capture = 1'b1;
            end
         end
         StReq: begin
            if (mem_gnt && (we_q || mem_rvalid)) begin
               state_d   = StDone;
               load_data = ~we_q;
            end else if (expired) begin
               state_d = StIdle;
               abort   = 1'b1;
            end else if (mem_gnt) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid) begin
               state_d   = StDone;
               load_data = 1'b1;
            end else if (expired) begin
               state_d = StIdle;
               abort   = 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (capture) begin
         cnt_d = '0;
      end else if (state_q == StReq || state_q == StWait) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         byte_q    <= 1'b0;
         off_q     <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= ((state_q == StIdle) & reject) | abort;
         if (capture) begin
            we_q    <= memwrite;
            byte_q  <= memread ? is_lb : is_sb;
            off_q   <= addr[1:0];
            addr_q  <= addr[ADDR_W-1:2];
            be_q    <= (memread ? is_lb : is_sb) ? (4'b0001 << addr[1:0]) : 4'hF;
            rd_q    <= rd;
            if (memwrite) begin
               wdata_q <= is_sb ? {4{wdata[7:0]}} : wdata;
            end else begin
               wdata_q <= '0;
            end
         end
         if (load_data) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= load_result;
         end
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      mem_req   = (state_q == StReq);
      mem_we    = we_q;
      mem_addr  = {addr_q, 2'b00};
      mem_be    = be_q;
      mem_wdata = wdata_q;
      done      = (state_q == StDone);
      wb_valid  = (state_q == StDone) & ~we_q & (rd_q != 5'd0);
      wb_rd     = wb_rd_q;
      wb_data   = wb_data_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized bench for mem_access_sequencer; expectations come from a
// transaction-level timing/data model driven by per-access gnt/rvalid delays.
module tb_mem_access_sequencer;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, memread, memwrite, is_lb, is_sb;
   logic [31:0] addr, wdata;
   logic [4:0]  rd;
   logic        busy, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        done, err;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_sequencer #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .memread    (memread),
      .memwrite   (memwrite),
      .is_lb      (is_lb),
      .is_sb      (is_sb),
      .addr       (addr),
      .wdata      (wdata),
      .rd         (rd),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs(input bit with_start);
      start    = with_start;
      memread  = 1'($urandom);
      memwrite = 1'($urandom);
      is_lb    = 1'($urandom);
      is_sb    = 1'($urandom);
      addr     = $urandom;
      wdata    = $urandom;
      rd       = 5'($urandom);
   endtask

   // g: cycles in REQ before gnt; rv: cycles after gnt until rvalid (loads).
   task automatic run_txn(input bit ld, input bit st, input bit bo, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r_d,
                          input logic [31:0] rdat, input int g, input int rv, input bit junk);
      bit          reject, ignore, ok;
      int          done_c, last_busy, last, req_last, off;
      logic [31:0] exp_be, exp_wd, exp_wb, byte_v;
      reject = (ld && st) || ((ld || st) && !bo && a[1:0] != 2'b00);
      ignore = !ld && !st;
      start = 1'b1; memread = ld; memwrite = st; is_lb = bo; is_sb = bo;
      addr = a; wdata = wd; rd = r_d;
      tick();
      scramble_inputs(1'b0);
      if (reject || ignore) begin
         check("reject_err", {31'b0, err}, {31'b0, reject});
         check("reject_busy", {31'b0, busy}, 32'd0);
         check("reject_req", {31'b0, mem_req}, 32'd0);
         tick();
         check("reject_err_clear", {31'b0, err}, 32'd0);
         check("reject_req2", {31'b0, mem_req}, 32'd0);
         return;
      end
      off      = int'(a[1:0]);
      ok       = st ? (g <= TO - 1) : (g + rv <= TO - 1);
      done_c   = st ? g + 2 : g + rv + 2;
      last_busy = ok ? done_c : TO;
      last     = last_busy + 1;
      req_last = (1 + g < TO) ? 1 + g : TO;
      exp_be   = bo ? (32'd1 << off) : 32'hF;
      exp_wd   = bo ? (wd & 32'hFF) * 32'h0101_0101 : wd;
      byte_v   = (rdat >> (8 * off)) & 32'hFF;
      exp_wb   = !bo ? rdat : (byte_v >= 32'd128 ? (byte_v | 32'hFFFF_FF00) : byte_v);
      for (int c = 1; c <= last; c++) begin
         check("busy", {31'b0, busy}, {31'b0, c <= last_busy});
         check("mem_req", {31'b0, mem_req}, {31'b0, c <= req_last});
         if (c <= req_last) begin
            check("mem_addr", mem_addr, a & ~32'h3);
            check("mem_be", {28'b0, mem_be}, exp_be);
            check("mem_we", {31'b0, mem_we}, {31'b0, st});
            if (st) check("mem_wdata", mem_wdata, exp_wd);
         end
         check("done", {31'b0, done}, {31'b0, ok && c == done_c});
         check("wb_valid", {31'b0, wb_valid}, {31'b0, ok && ld && r_d != 0 && c == done_c});
         check("err", {31'b0, err}, {31'b0, !ok && c == TO + 1});
         if (ok && ld && r_d != 0 && c >= done_c) begin
            check("wb_data", wb_data, exp_wb);
            check("wb_rd", {27'b0, wb_rd}, {27'b0, r_d});
         end
         mem_gnt = (c == 1 + g) && (c <= TO);
         if (ld && c == 1 + g + rv && c <= TO) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdat;
         end else begin
            mem_rvalid = (c == last || (ok && c == done_c)) ? 1'($urandom) : 1'b0;
            mem_rdata  = $urandom;
         end
         scramble_inputs(junk && c <= last_busy);
         tick();
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      scramble_inputs(1'b0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) tick();
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_req", {31'b0, mem_req}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst_be", {28'b0, mem_be}, 32'd0);
      rst_n = 1'b1;
      tick();

      run_txn(1, 0, 1, 32'h1003, 32'h0, 5'd5, 32'h80AA_BBCC, 0, 1, 0);
      check("lb_const", wb_data, 32'hFFFF_FF80);
      run_txn(0, 1, 1, 32'h2002, 32'h1234_5677, 5'd0, 32'h0, 0, 0, 0);
      run_txn(1, 0, 0, 32'h10, 32'h0, 5'd3, 32'h0, 40, 0, 0);
      run_txn(1, 0, 0, 32'h6, 32'h0, 5'd3, 32'h0, 0, 0, 0);
      run_txn(1, 0, 0, 32'h20, 32'h0, 5'd0, 32'hDEAD_BEEF, 1, 1, 0);
      run_txn(1, 1, 0, 32'h30, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(0, 0, 0, 32'h30, 32'h0, 5'd4, 32'h0, 0, 0, 0);
      run_txn(1, 0, 0, 32'h44, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0, 1);

      // Reset while waiting on rvalid abandons the access.
      start = 1'b1; memread = 1'b1; memwrite = 1'b0; is_lb = 1'b0; is_sb = 1'b0;
      addr = 32'h40; rd = 5'd7;
      tick();
      start = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_req", {31'b0, mem_req}, 32'd0);
      check("arst_addr", mem_addr, 32'd0);
      check("arst_wb_data", wb_data, 32'd0);
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("arst_done", {31'b0, done}, 32'd0);
         check("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
         check("arst_busy2", {31'b0, busy}, 32'd0);
         tick();
      end
      run_txn(1, 0, 0, 32'h40, 32'h0, 5'd7, 32'h5555_AAAA, 0, 1, 0);

      for (int n = 0; n < 200; n++) begin
         bit ld, st, bo, junk;
         int sel, g, rv;
         logic [31:0] a;
         sel = $urandom_range(0, 19);
         ld  = (sel < 9) || (sel == 18);
         st  = (sel >= 9 && sel < 18) || (sel == 18);
         bo  = 1'($urandom);
         a   = $urandom;
         if (!bo && $urandom_range(0, 9) < 7) a[1:0] = 2'b00;
         g   = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
         rv  = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 3);
         junk = 1'($urandom);
         run_txn(ld, st, bo, a, $urandom, 5'($urandom), $urandom, g, rv, junk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
